fft_stage_sequencer: RTL and testbench

//  Sequences an in-place radix-2 DIF FFT of N points over ONE shared, pipelined

---
 rtl/fft_pkg.sv | 47 ++++
 rtl/fft_stage_sequencer_if.sv | 64 ++++++
 rtl/fft_seq_addr_gen.sv | 47 ++++
 rtl/fft_stage_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-2 DIF FFT stage sequencer:
//   - default N / LOG2N / BF_LAT constants
//   - sequencer state encoding
//   - stage_bits(): width of the stage counter for a given LOG2N
//   - bitrev():     bit-reverse the low 'width' bits of a value
// Optional feature macro used by the files that import this package:
//   FFT_SEQ_SCALE_EN (per-stage result scaling strobe)
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int N_DEF      = 8;
    localparam int LOG2N_DEF  = 3;
    localparam int BF_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STAGE,
        ST_DRAIN,
        ST_UNLOAD,
        ST_DONE
    } seq_state_t;

    // The stage counter must hold 0..LOG2N-1; never narrower than one bit.
    function automatic int stage_bits(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    // LSBs of the input are shifted out one by one into the result's LSB,
    // so after 'width' steps the first bit taken sits at position width-1.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] src;
        logic [31:0] res;
        src = value;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res = {res[30:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer_if
// Bundle between the FFT stage sequencer and the rest of the system
// (top-level control plus butterfly / register-file datapath).
//   master modport : the sequencer (samples start, drives everything else)
//   slave  modport : the system/datapath side
// Signals: start, busy, load_en, bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx,
//          bf_wr_en, bf_wr_addr_a, bf_wr_addr_b, out_rd_addr, out_index,
//          output_valid, done
// With FFT_SEQ_SCALE_EN defined, also scale_mask (to sequencer) and
// bf_scale (from sequencer).
// ---------------------------------------------------------------------------
interface fft_stage_sequencer_if #(
    parameter int LOG2N = fft_pkg::LOG2N_DEF
);

    logic             start;
    logic             busy;
    logic             load_en;
    logic             bf_valid;
    logic [LOG2N-1:0] bf_addr_a;
    logic [LOG2N-1:0] bf_addr_b;
    logic [LOG2N-2:0] bf_tw_idx;
    logic             bf_wr_en;
    logic [LOG2N-1:0] bf_wr_addr_a;
    logic [LOG2N-1:0] bf_wr_addr_b;
    logic [LOG2N-1:0] out_rd_addr;
    logic [LOG2N-1:0] out_index;
    logic             output_valid;
    logic             done;
`ifdef FFT_SEQ_SCALE_EN
    logic [LOG2N-1:0] scale_mask;
    logic             bf_scale;

    modport master (
        input  start, scale_mask,
        output busy, load_en, bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx,
               bf_wr_en, bf_wr_addr_a, bf_wr_addr_b, out_rd_addr, out_index,
               output_valid, done, bf_scale
    );

    modport slave (
        output start, scale_mask,
        input  busy, load_en, bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx,
               bf_wr_en, bf_wr_addr_a, bf_wr_addr_b, out_rd_addr, out_index,
               output_valid, done, bf_scale
    );
`else
    modport master (
        input  start,
        output busy, load_en, bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx,
               bf_wr_en, bf_wr_addr_a, bf_wr_addr_b, out_rd_addr, out_index,
               output_valid, done
    );

    modport slave (
        output start,
        input  busy, load_en, bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx,
               bf_wr_en, bf_wr_addr_a, bf_wr_addr_b, out_rd_addr, out_index,
               output_valid, done
    );
`endif

endinterface

// File: rtl/fft_seq_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_seq_addr_gen
// Combinational butterfly address generator for an in-place radix-2 DIF FFT.
// For stage s and butterfly k:
//   span = N >> (s+1), j = k mod span,
//   a = (k div span)*2*span + j, b = a + span, tw = j << s
// Because span is a power of two, div/mod reduce to masking and the
// "*2" is a one-bit left shift of the high part of k.
// Ports:
//   stage  in  current stage index
//   k      in  butterfly index within the stage
//   addr_a out operand/result A address
//   addr_b out operand/result B address
//   tw_idx out twiddle exponent
// ---------------------------------------------------------------------------
module fft_seq_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int SW    = stage_bits(LOG2N)
)(
    input  logic [SW-1:0]    stage,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx
);

    localparam logic [LOG2N-1:0] HALF  = {1'b1, {(LOG2N-1){1'b0}}};
    localparam logic [LOG2N-2:0] ALL1S = '1;

    logic [LOG2N-1:0] span;
    logic [LOG2N-2:0] low_mask;
    logic [LOG2N-2:0] j;

    // low_mask = span-1 computed directly in the narrow k width, since
    // (N/2-1) >> s equals (N >> (s+1)) - 1.
    always_comb begin
        span     = HALF >> stage;
        low_mask = ALL1S >> stage;
        j        = k & low_mask;
        addr_a   = {k & ~low_mask, 1'b0} | {1'b0, j};
        addr_b   = addr_a | span;
        tw_idx   = j << stage;
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
// Sequences an in-place radix-2 DIF FFT of N points over one shared,
// pipelined butterfly unit: load, LOG2N stages of N/2 butterflies (each
// followed by a BF_LAT-cycle drain), bit-reversed unload, done pulse.
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous active-high reset, aborts any frame
//   bus   master modport of fft_stage_sequencer_if (see that file)
// Optional feature: FFT_SEQ_SCALE_EN adds scale_mask / bf_scale, where
// bf_scale = scale_mask[stage] (mask captured on the accepted start),
// aligned with bf_valid.
// All outputs are registered.
// ---------------------------------------------------------------------------
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int LOG2N  = LOG2N_DEF,
    parameter int BF_LAT = BF_LAT_DEF
)(
    input logic                  clk,
    input logic                  reset,
    fft_stage_sequencer_if.master bus
);

    localparam int SW = stage_bits(LOG2N);
    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
    localparam logic [LOG2N-2:0] K_LAST     = (LOG2N-1)'(N/2 - 1);
    localparam logic [LOG2N-1:0] U_LAST     = LOG2N'(N - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(BF_LAT - 1);

    seq_state_t       state;
    logic [SW-1:0]    stage_cnt;
    logic [LOG2N-2:0] k_cnt;
    logic [DW-1:0]    drain_cnt;
    logic [LOG2N-1:0] unload_cnt;
    logic [LOG2N-1:0] unload_nxt;

    logic [SW-1:0]    gen_stage;
    logic [LOG2N-2:0] gen_k;
    logic             issue;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-2:0] gen_tw;

    logic             busy_q;
    logic             load_en_q;
    logic             bf_valid_q;
    logic [LOG2N-1:0] bf_addr_a_q;
    logic [LOG2N-1:0] bf_addr_b_q;
    logic [LOG2N-2:0] bf_tw_q;
    logic [LOG2N-1:0] out_rd_addr_q;
    logic [LOG2N-1:0] out_index_q;
    logic             output_valid_q;
    logic             done_q;

    logic [BF_LAT-1:0] wb_valid;
    logic [LOG2N-1:0]  wb_addr_a [BF_LAT];
    logic [LOG2N-1:0]  wb_addr_b [BF_LAT];

`ifdef FFT_SEQ_SCALE_EN
    logic [LOG2N-1:0] scale_q;
    logic             bf_scale_q;
`endif

    // Counters hold the butterfly currently on the outputs; this block looks
    // one step ahead so the registered outputs carry the butterfly issued in
    // the next cycle. A drain that ends on a non-final stage issues the first
    // butterfly of the following stage.
    always_comb begin
        gen_stage = stage_cnt;
        gen_k     = k_cnt;
        issue     = 1'b0;
        case (state)
            ST_LOAD: begin
                gen_stage = '0;
                gen_k     = '0;
                issue     = 1'b1;
            end
            ST_STAGE: begin
                gen_k = k_cnt + (LOG2N-1)'(1);
                issue = (k_cnt != K_LAST);
            end
            ST_DRAIN: begin
                gen_stage = stage_cnt + SW'(1);
                gen_k     = '0;
                issue     = (drain_cnt == DRAIN_LAST) && (stage_cnt != STAGE_LAST);
            end
            default: begin
            end
        endcase
    end

    assign unload_nxt = unload_cnt + LOG2N'(1);

    fft_seq_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .stage  (gen_stage),
        .k      (gen_k),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // Main FSM with its counters and registered outputs. Addresses and unload
    // indices are forced to zero whenever their qualifying strobe is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            stage_cnt      <= '0;
            k_cnt          <= '0;
            drain_cnt      <= '0;
            unload_cnt     <= '0;
            busy_q         <= 1'b0;
            load_en_q      <= 1'b0;
            bf_valid_q     <= 1'b0;
            bf_addr_a_q    <= '0;
            bf_addr_b_q    <= '0;
            bf_tw_q        <= '0;
            out_rd_addr_q  <= '0;
            out_index_q    <= '0;
            output_valid_q <= 1'b0;
            done_q         <= 1'b0;
`ifdef FFT_SEQ_SCALE_EN
            scale_q        <= '0;
            bf_scale_q     <= 1'b0;
`endif
        end else begin
            load_en_q      <= 1'b0;
            done_q         <= 1'b0;
            output_valid_q <= 1'b0;
            out_rd_addr_q  <= '0;
            out_index_q    <= '0;
            bf_valid_q     <= issue;
            bf_addr_a_q    <= issue ? gen_a  : '0;
            bf_addr_b_q    <= issue ? gen_b  : '0;
            bf_tw_q        <= issue ? gen_tw : '0;
`ifdef FFT_SEQ_SCALE_EN
            bf_scale_q     <= issue ? scale_q[gen_stage] : 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_LOAD;
                        busy_q    <= 1'b1;
                        load_en_q <= 1'b1;
                        stage_cnt <= '0;
                        k_cnt     <= '0;
`ifdef FFT_SEQ_SCALE_EN
                        scale_q   <= bus.scale_mask;
`endif
                    end
                end
                ST_LOAD: begin
                    state     <= ST_STAGE;
                    stage_cnt <= '0;
                    k_cnt     <= '0;
                end
                ST_STAGE: begin
                    if (k_cnt == K_LAST) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        k_cnt <= k_cnt + (LOG2N-1)'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        if (stage_cnt == STAGE_LAST) begin
                            state          <= ST_UNLOAD;
                            unload_cnt     <= '0;
                            output_valid_q <= 1'b1;
                        end else begin
                            state     <= ST_STAGE;
                            stage_cnt <= stage_cnt + SW'(1);
                            k_cnt     <= '0;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (unload_cnt == U_LAST) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        unload_cnt     <= unload_nxt;
                        output_valid_q <= 1'b1;
                        out_index_q    <= unload_nxt;
                        out_rd_addr_q  <= LOG2N'(bitrev(32'(unload_nxt), LOG2N));
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-back delay line: the issued {a,b} reappear exactly BF_LAT cycles
    // later as the write strobe, matching the butterfly unit's latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                wb_addr_a[i] <= '0;
                wb_addr_b[i] <= '0;
            end
        end else begin
            wb_valid[0]  <= bf_valid_q;
            wb_addr_a[0] <= bf_addr_a_q;
            wb_addr_b[0] <= bf_addr_b_q;
            for (int i = 1; i < BF_LAT; i++) begin
                wb_valid[i]  <= wb_valid[i-1];
                wb_addr_a[i] <= wb_addr_a[i-1];
                wb_addr_b[i] <= wb_addr_b[i-1];
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.load_en      = load_en_q;
    assign bus.bf_valid     = bf_valid_q;
    assign bus.bf_addr_a    = bf_addr_a_q;
    assign bus.bf_addr_b    = bf_addr_b_q;
    assign bus.bf_tw_idx    = bf_tw_q;
    assign bus.bf_wr_en     = wb_valid[BF_LAT-1];
    assign bus.bf_wr_addr_a = wb_addr_a[BF_LAT-1];
    assign bus.bf_wr_addr_b = wb_addr_b[BF_LAT-1];
    assign bus.out_rd_addr  = out_rd_addr_q;
    assign bus.out_index    = out_index_q;
    assign bus.output_valid = output_valid_q;
    assign bus.done         = done_q;
`ifdef FFT_SEQ_SCALE_EN
    assign bus.bf_scale     = bf_scale_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_sequencer
// Self-checking bench for fft_stage_sequencer with N=8, LOG2N=3, BF_LAT=2.
// A directed frame is checked against a hand-filled table, then mid-frame
// reset, continuous start and random start traffic are checked cycle by
// cycle against a frame-timeline reference model.
// ---------------------------------------------------------------------------
module tb_fft_stage_sequencer;

    localparam int N      = 8;
    localparam int LOG2N  = 3;
    localparam int BF_LAT = 2;
    localparam int STAGE_CYC = N/2 + BF_LAT;
    localparam int UNLOAD_AT = 2 + LOG2N*STAGE_CYC;
    localparam int DONE_AT   = UNLOAD_AT + N;
    localparam int PERIOD    = DONE_AT + 1;
`ifdef FFT_SEQ_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif

    typedef struct packed {
        logic       busy;
        logic       load_en;
        logic       bf_valid;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
        logic       scale;
        logic       wr_en;
        logic [2:0] wa;
        logic [2:0] wb;
        logic       ov;
        logic [2:0] rd;
        logic [2:0] idx;
        logic       done;
    } obs_t;

    typedef struct {
        logic       start;
        logic [2:0] mask;
        obs_t       want;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    int   frame_edge = -1000;
    logic [2:0] frame_mask = '0;

    vec_t tbl [32];
    int   lit_a  [12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
    int   lit_b  [12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
    int   lit_tw [12] = '{0,1,2,3, 0,2,0,2, 0,0,0,0};
    int   lit_rd [8]  = '{0,4,2,6,1,5,3,7};

    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.LOG2N(LOG2N)) bus();

    fft_stage_sequencer #(
        .N      (N),
        .LOG2N  (LOG2N),
        .BF_LAT (BF_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    function automatic obs_t sample();
        obs_t o;
        o          = '0;
        o.busy     = bus.busy;
        o.load_en  = bus.load_en;
        o.bf_valid = bus.bf_valid;
        o.a        = bus.bf_addr_a;
        o.b        = bus.bf_addr_b;
        o.tw       = bus.bf_tw_idx;
        o.wr_en    = bus.bf_wr_en;
        o.wa       = bus.bf_wr_addr_a;
        o.wb       = bus.bf_wr_addr_b;
        o.ov       = bus.output_valid;
        o.rd       = bus.out_rd_addr;
        o.idx      = bus.out_index;
        o.done     = bus.done;
`ifdef FFT_SEQ_SCALE_EN
        o.scale    = bus.bf_scale;
`endif
        return o;
    endfunction

    // Reference: which butterfly (if any) is issued at cycle c of a frame.
    function automatic bit issue_at(input int c, output int s, output int k);
        int p;
        p = c - 2;
        s = 0;
        k = 0;
        if (p < 0 || p >= LOG2N*STAGE_CYC) return 1'b0;
        s = p / STAGE_CYC;
        k = p % STAGE_CYC;
        return (k < N/2);
    endfunction

    // Reference: everything visible at cycle c after the start-sampling edge.
    function automatic obs_t model_at(input int c, input logic [2:0] mask);
        obs_t o;
        int s, k, span, j, a, r, u;
        o = '0;
        o.busy    = (c >= 1 && c < DONE_AT);
        o.load_en = (c == 1);
        if (issue_at(c, s, k)) begin
            span       = N >> (s + 1);
            j          = k % span;
            a          = (k / span) * 2 * span + j;
            o.bf_valid = 1'b1;
            o.a        = 3'(a);
            o.b        = 3'(a + span);
            o.tw       = 2'(j << s);
            o.scale    = SCALE_ON && (((mask >> s) & 3'd1) != 3'd0);
        end
        if (issue_at(c - BF_LAT, s, k)) begin
            span    = N >> (s + 1);
            j       = k % span;
            a       = (k / span) * 2 * span + j;
            o.wr_en = 1'b1;
            o.wa    = 3'(a);
            o.wb    = 3'(a + span);
        end
        if (c >= UNLOAD_AT && c < DONE_AT) begin
            u = c - UNLOAD_AT;
            r = 0;
            for (int bit_i = 0; bit_i < LOG2N; bit_i++)
                if (((u >> bit_i) & 1) == 1) r = r + (1 << (LOG2N - 1 - bit_i));
            o.ov  = 1'b1;
            o.idx = 3'(u);
            o.rd  = 3'(r);
        end
        o.done = (c == DONE_AT);
        return o;
    endfunction

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, got, want);
        end
    endtask

    // Drive one cycle of start/mask, advance the model and check the outputs.
    task automatic apply_stimulus(input logic st, input logic [2:0] mask);
        bus.start = st;
`ifdef FFT_SEQ_SCALE_EN
        bus.scale_mask = mask;
`endif
        @(posedge clk);
        if (st && (edge_cnt - frame_edge >= PERIOD)) begin
            frame_edge = edge_cnt;
            frame_mask = mask;
        end
        edge_cnt++;
        #1;
        check_output($sformatf("model_c%0d", edge_cnt - frame_edge),
                     64'(sample()), 64'(model_at(edge_cnt - frame_edge, frame_mask)));
    endtask

    initial begin
        int s, k, r;

        // Directed frame table; row i drives start before edge i and holds
        // the outputs expected in cycle i+1.
        for (int i = 0; i < 32; i++) begin
            tbl[i].start     = 1'b0;
            tbl[i].mask      = 3'b010;
            tbl[i].want      = '0;
            tbl[i].want.busy = (i <= 26);
        end
        tbl[0].start        = 1'b1;
        tbl[0].mask         = 3'b101;
        tbl[0].want.load_en = 1'b1;
        tbl[5].start        = 1'b1;
        tbl[21].start       = 1'b1;
        tbl[27].start       = 1'b1;
        tbl[28].start       = 1'b1;
        for (int n = 0; n < 12; n++) begin
            s = n / 4;
            k = n % 4;
            r = 1 + 6*s + k;
            tbl[r].want.bf_valid = 1'b1;
            tbl[r].want.a        = 3'(lit_a[n]);
            tbl[r].want.b        = 3'(lit_b[n]);
            tbl[r].want.tw       = 2'(lit_tw[n]);
            tbl[r].want.scale    = SCALE_ON && (s != 1);
            tbl[r+2].want.wr_en  = 1'b1;
            tbl[r+2].want.wa     = 3'(lit_a[n]);
            tbl[r+2].want.wb     = 3'(lit_b[n]);
        end
        for (int i = 0; i < 8; i++) begin
            tbl[19+i].want.ov  = 1'b1;
            tbl[19+i].want.idx = 3'(i);
            tbl[19+i].want.rd  = 3'(lit_rd[i]);
        end
        tbl[27].want.done = 1'b1;

        reset     = 1'b1;
        bus.start = 1'b0;
`ifdef FFT_SEQ_SCALE_EN
        bus.scale_mask = '0;
`endif
        #12;
        check_output("reset_state", 64'(sample()), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] directed frame table");
        for (int i = 0; i < 32; i++) begin
            bus.start = tbl[i].start;
`ifdef FFT_SEQ_SCALE_EN
            bus.scale_mask = tbl[i].mask;
`endif
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d", i), 64'(sample()), 64'(tbl[i].want));
        end

        $display("[TB] reset during stage 1, k=2");
        frame_edge = -1000;
        apply_stimulus(1'b1, 3'b101);
        for (int i = 0; i < 9; i++) apply_stimulus(1'b0, 3'b000);
        check_output("stage1_k2_point", {61'(0), bus.bf_valid, bus.bf_addr_a, bus.bf_addr_b} >> 0,
                     {57'(0), 1'b1, 3'd4, 3'd6});
        #2 reset = 1'b1;
        #1;
        check_output("reset_async", 64'(sample()), 64'(0));
        @(posedge clk);
        #1;
        check_output("reset_hold", 64'(sample()), 64'(0));
        reset = 1'b0;
        for (int i = 0; i <= BF_LAT; i++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("post_reset_idle%0d", i), 64'(sample()), 64'(0));
        end
        frame_edge = -1000;
        apply_stimulus(1'b1, 3'b011);
        for (int i = 0; i < PERIOD + 2; i++) apply_stimulus(1'b0, 3'($urandom_range(0, 7)));

        $display("[TB] start held high");
        for (int i = 0; i < 70; i++) apply_stimulus(1'b1, 3'($urandom_range(0, 7)));

        $display("[TB] random start traffic");
        for (int i = 0; i < 300; i++)
            apply_stimulus(($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)));
        for (int i = 0; i < PERIOD + 2; i++) apply_stimulus(1'b0, 3'b000);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
